// File: rtl/sig_pkg.sv
// Shared sample type and carrier constants for the PWM output stage.
package sig_pkg;
   localparam int DATA_W = 8;
   localparam int PRE_W  = 4;

   typedef logic [DATA_W-1:0] sample_t;

   localparam sample_t CARRIER_MAX = '1;
endpackage

// File: rtl/pwm_prescaler.sv
// Carrier prescaler: one-cycle tick every prescale+1 enabled cycles.
module pwm_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);
   logic [PRESCALE_W-1:0] cnt_q, cnt_d, lim_q, lim_d, lim;

   // The limit is sampled only when the count restarts, so a mid-count change waits its turn.
   assign lim  = (cnt_q == '0) ? prescale : lim_q;
   assign tick = en && (cnt_q == lim);

   always_comb begin
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (en) begin
         lim_d = lim;
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         lim_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end
endmodule

// File: rtl/pwm_dac.sv
// Dual-channel double-buffered PWM DAC stage. Define PWM_CENTER_EN for a
// centre-aligned (triangle) carrier; default is an edge-aligned sawtooth.
module pwm_dac
   import sig_pkg::*;
#(
   parameter int D_WIDTH    = DATA_W,
   parameter int PRESCALE_W = PRE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [D_WIDTH-1:0]    s_data1,
   input  logic [D_WIDTH-1:0]    s_data2,
   input  logic                  clr_underrun,
   output logic                  pwm1,
   output logic                  pwm2,
   output logic                  period_start,
   output logic                  underrun
);
   localparam logic [D_WIDTH-1:0] CMAX = '1;

   logic               tick, hs, wrap;
   logic [D_WIDTH-1:0] car_q, car_d;
   logic [D_WIDTH-1:0] act1_q, act1_d, act2_q, act2_d;
   logic [D_WIDTH-1:0] shd1_q, shd1_d, shd2_q, shd2_d;
   logic               shd_full_q, shd_full_d;
   logic               pwm1_q, pwm1_d, pwm2_q, pwm2_d;
   logic               ps_q, ur_q, ur_d;

   pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .prescale (prescale),
      .tick     (tick)
   );

   assign s_ready = !shd_full_q;
   assign hs      = s_valid && s_ready;

`ifdef PWM_CENTER_EN
   logic dir_q, dir_d;  // 1 while counting down

   always_comb begin
      car_d = car_q;
      dir_d = dir_q;
      wrap  = 1'b0;
      if (tick) begin
         if (!dir_q) begin
            if (car_q == CMAX) begin
               dir_d = 1'b1;
               car_d = CMAX - 1'b1;
            end else begin
               car_d = car_q + 1'b1;
            end
         end else if (car_q == D_WIDTH'(1)) begin
            wrap  = 1'b1;
            dir_d = 1'b0;
            car_d = '0;
         end else begin
            car_d = car_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dir_q <= 1'b0;
      else     dir_q <= dir_d;
   end
`else
   assign wrap  = tick && (car_q == CMAX);
   assign car_d = tick ? car_q + 1'b1 : car_q;
`endif

   // An empty shadow at wrap takes a same-cycle pair directly; otherwise the old pair replays.
   always_comb begin
      act1_d     = act1_q;
      act2_d     = act2_q;
      shd1_d     = shd1_q;
      shd2_d     = shd2_q;
      shd_full_d = shd_full_q;
      ur_d       = ur_q;
      if (clr_underrun) ur_d = 1'b0;
      if (hs) begin
         shd1_d = s_data1;
         shd2_d = s_data2;
      end
      if (wrap) begin
         shd_full_d = 1'b0;
         if (shd_full_q) begin
            act1_d = shd1_q;
            act2_d = shd2_q;
         end else if (hs) begin
            act1_d = s_data1;
            act2_d = s_data2;
         end else begin
            ur_d = 1'b1;
         end
      end else if (hs) begin
         shd_full_d = 1'b1;
      end
   end

   assign pwm1_d = en && (act1_q > car_q);
   assign pwm2_d = en && (act2_q > car_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         car_q      <= '0;
         act1_q     <= '0;
         act2_q     <= '0;
         shd1_q     <= '0;
         shd2_q     <= '0;
         shd_full_q <= 1'b0;
         pwm1_q     <= 1'b0;
         pwm2_q     <= 1'b0;
         ps_q       <= 1'b0;
         ur_q       <= 1'b0;
      end else begin
         car_q      <= car_d;
         act1_q     <= act1_d;
         act2_q     <= act2_d;
         shd1_q     <= shd1_d;
         shd2_q     <= shd2_d;
         shd_full_q <= shd_full_d;
         pwm1_q     <= pwm1_d;
         pwm2_q     <= pwm2_d;
         ps_q       <= wrap;
         ur_q       <= ur_d;
      end
   end

   assign pwm1         = pwm1_q;
   assign pwm2         = pwm2_q;
   assign period_start = ps_q;
   assign underrun     = ur_q;
endmodule
